// File: rtl/port_rd_backend.sv
// Egress read backend: turns packet descriptors into SRAM word requests
// and streams the returned words to the port with SOP/EOP framing.
module port_rd_backend #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pkt_vld,
    input  logic [8:0]  pkt_length,
    output logic        pkt_rdy,
    output logic        xfer_req,
    input  logic        xfer_data_vld,
    input  logic [15:0] xfer_data,
    input  logic        ready,
    output logic        rd_sop,
    output logic        rd_eop,
    output logic        rd_vld,
    output logic [15:0] rd_data,
    output logic        len_err
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 2;

    typedef enum logic [1:0] {
        IDLE,
        SOP,
        DATA,
        EOP
    } state_t;

    state_t         state;
    state_t         state_n;
    logic [8:0]     len;
    logic [8:0]     req_cnt;
    logic [8:0]     out_cnt;
    logic [AW:0]    fifo_cnt;
    logic [1:0]     inflight;
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic [15:0]    mem [FIFO_DEPTH];
    logic [CW-1:0]  credit;
    logic           accept;
    logic           zero_len;
    logic           active;
    logic           issue;
    logic           push;
    logic           pop;
    logic           last_beat;

    // The request sitting in xfer_req has not reached inflight yet,
    // so it is charged against the FIFO credit as well.
    always_comb begin
        accept    = pkt_vld && pkt_rdy;
        zero_len  = (pkt_length == 9'd0);
        active    = (state == SOP) || (state == DATA);
        credit    = CW'(fifo_cnt) + CW'(inflight) + CW'(xfer_req);
        issue     = active && (req_cnt < len)
                    && (credit < CW'(FIFO_DEPTH));
        push      = active && xfer_data_vld;
        pop       = (state == DATA) && ready && (fifo_cnt != '0);
        last_beat = pop && ((out_cnt + 9'd1) == len);
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE: if (accept && !zero_len) state_n = SOP;
            SOP:  state_n = DATA;
            DATA: if (last_beat) state_n = EOP;
            EOP:  state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            pkt_rdy  <= 1'b0;
            xfer_req <= 1'b0;
            rd_sop   <= 1'b0;
            rd_eop   <= 1'b0;
            rd_vld   <= 1'b0;
            rd_data  <= '0;
            len_err  <= 1'b0;
            len      <= '0;
            req_cnt  <= '0;
            out_cnt  <= '0;
            fifo_cnt <= '0;
            inflight <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
        end else begin
            state    <= state_n;
            pkt_rdy  <= (state_n == IDLE);
            xfer_req <= issue;
            rd_sop   <= (state == SOP);
            rd_eop   <= (state == EOP);
            rd_vld   <= pop;
            len_err  <= accept && zero_len;
            if (accept) begin
                len     <= pkt_length;
                req_cnt <= '0;
                out_cnt <= '0;
            end else begin
                if (issue) req_cnt <= req_cnt + 9'd1;
                if (pop)   out_cnt <= out_cnt + 9'd1;
            end
            inflight <= inflight + 2'(xfer_req) - 2'(push);
            fifo_cnt <= fifo_cnt + (AW+1)'(push) - (AW+1)'(pop);
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop) begin
                rd_data <= mem[rd_ptr];
                rd_ptr  <= rd_ptr + AW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= xfer_data;
    end

endmodule

// File: tb/tb_port_rd_backend.sv
// Directed bench for port_rd_backend: packet table plus stall,
// mid-packet reset and back-to-back corner sequences.
module tb_port_rd_backend;

    logic        clk;
    logic        rst_n;
    logic        pkt_vld;
    logic [8:0]  pkt_length;
    logic        pkt_rdy;
    logic        xfer_req;
    logic        xfer_data_vld;
    logic [15:0] xfer_data;
    logic        ready;
    logic        rd_sop;
    logic        rd_eop;
    logic        rd_vld;
    logic [15:0] rd_data;
    logic        len_err;

    port_rd_backend #(.FIFO_DEPTH(4)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .pkt_vld       (pkt_vld),
        .pkt_length    (pkt_length),
        .pkt_rdy       (pkt_rdy),
        .xfer_req      (xfer_req),
        .xfer_data_vld (xfer_data_vld),
        .xfer_data     (xfer_data),
        .ready         (ready),
        .rd_sop        (rd_sop),
        .rd_eop        (rd_eop),
        .rd_vld        (rd_vld),
        .rd_data       (rd_data),
        .len_err       (len_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int len;
        int mode;
        int beats;
        int reqs;
        int sops;
        int eops;
        int errs;
    } vec_t;

    vec_t tbl [7];

    int nvec = 0;
    int nerr = 0;

    int n_req, n_beat, n_sop, n_eop, n_err;
    int bad_data, bad_seq, overlap, max_out, min_gap;
    int cyc = 0;
    int last_vld_cyc = -1000;
    int hold_en = 0;
    logic [15:0] last_data = '0;
    logic [15:0] sb [$];
    logic [15:0] wcnt = 16'h1000;
    logic        v1 = 1'b0, v2 = 1'b0;
    logic [15:0] d1 = '0, d2 = '0;
    logic [15:0] exp_w;

    // SRAM returns each word two cycles after its request; the scoreboard
    // records words in request order.
    always @(negedge clk) begin
        cyc = cyc + 1;
        xfer_data_vld = v2;
        xfer_data = v2 ? d2 : 16'($urandom);
        v2 = v1;
        d2 = d1;
        v1 = xfer_req;
        if (xfer_req) begin
            d1 = wcnt;
            sb.push_back(wcnt);
            wcnt = wcnt + 16'd1;
            n_req = n_req + 1;
        end
        if (rd_vld) begin
            n_beat = n_beat + 1;
            last_vld_cyc = cyc;
            if (n_sop == 0) bad_seq = bad_seq + 1;
            if (sb.size() == 0) begin
                bad_data = bad_data + 1;
            end else begin
                exp_w = sb.pop_front();
                if (rd_data != exp_w) bad_data = bad_data + 1;
            end
        end else if (hold_en != 0 && rd_data != last_data) begin
            bad_data = bad_data + 1;
        end
        last_data = rd_data;
        if (rd_sop) begin
            n_sop = n_sop + 1;
            if (cyc - last_vld_cyc - 1 < min_gap)
                min_gap = cyc - last_vld_cyc - 1;
        end
        if (rd_eop) begin
            n_eop = n_eop + 1;
            if (cyc - last_vld_cyc != 1) bad_seq = bad_seq + 1;
        end
        if (len_err) n_err = n_err + 1;
        if (int'(rd_sop) + int'(rd_vld) + int'(rd_eop) > 1)
            overlap = overlap + 1;
        if (n_req - n_beat > max_out) max_out = n_req - n_beat;
    end

    task automatic chk(input string nm, input int act, input int exp);
        nvec = nvec + 1;
        if (act != exp) begin
            nerr = nerr + 1;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic chk_le(input string nm, input int act, input int lim);
        nvec = nvec + 1;
        if (act > lim) begin
            nerr = nerr + 1;
            $display("FAIL %s: got %0d expected <= %0d", nm, act, lim);
        end
    endtask

    task automatic chk_ge(input string nm, input int act, input int lim);
        nvec = nvec + 1;
        if (act < lim) begin
            nerr = nerr + 1;
            $display("FAIL %s: got %0d expected >= %0d", nm, act, lim);
        end
    endtask

    task automatic clr();
        n_req = 0;
        n_beat = 0;
        n_sop = 0;
        n_eop = 0;
        n_err = 0;
        bad_data = 0;
        bad_seq = 0;
        overlap = 0;
        max_out = 0;
        min_gap = 1000;
        last_vld_cyc = -1000;
    endtask

    task automatic wait_rdy();
        int ok;
        ok = 0;
        for (int i = 0; i < 50 && ok == 0; i++) begin
            @(negedge clk);
            if (pkt_rdy) ok = 1;
        end
        chk("pkt_rdy_seen", ok, 1);
    endtask

    task automatic send(input int len);
        pkt_length = 9'(len);
        pkt_vld = 1'b1;
        @(negedge clk);
        pkt_vld = 1'b0;
    endtask

    task automatic run_pkt(input int len, input int mode, output int done);
        clr();
        wait_rdy();
        send(len);
        done = 0;
        for (int i = 0; i < 3000 && done == 0; i++) begin
            case (mode)
                0: ready = 1'b1;
                1: ready = ((i % 2) == 0);
                default: ready = ((i % 3) == 0);
            endcase
            @(negedge clk);
            if (len == 0) begin
                if (i >= 8) done = 1;
            end else if (n_eop != 0) begin
                done = 1;
            end
        end
        ready = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic chk_common(input string tag);
        chk({tag, "_data"}, bad_data, 0);
        chk({tag, "_seq"}, bad_seq, 0);
        chk({tag, "_overlap"}, overlap, 0);
        chk_le({tag, "_outstanding"}, max_out, 4);
        chk({tag, "_sb_left"}, sb.size(), 0);
    endtask

    initial begin
        int done;
        int ok;
        int b;
        int drop;

        tbl[0] = '{len: 3,  mode: 0, beats: 3,  reqs: 3,  sops: 1, eops: 1, errs: 0};
        tbl[1] = '{len: 8,  mode: 1, beats: 8,  reqs: 8,  sops: 1, eops: 1, errs: 0};
        tbl[2] = '{len: 0,  mode: 0, beats: 0,  reqs: 0,  sops: 0, eops: 0, errs: 1};
        tbl[3] = '{len: 1,  mode: 0, beats: 1,  reqs: 1,  sops: 1, eops: 1, errs: 0};
        tbl[4] = '{len: 4,  mode: 1, beats: 4,  reqs: 4,  sops: 1, eops: 1, errs: 0};
        tbl[5] = '{len: 16, mode: 2, beats: 16, reqs: 16, sops: 1, eops: 1, errs: 0};
        tbl[6] = '{len: 5,  mode: 2, beats: 5,  reqs: 5,  sops: 1, eops: 1, errs: 0};

        rst_n = 1'b0;
        pkt_vld = 1'b0;
        pkt_length = '0;
        ready = 1'b0;
        clr();
        repeat (2) @(negedge clk);
        chk("reset_pkt_rdy", int'(pkt_rdy), 0);
        chk("reset_xfer_req", int'(xfer_req), 0);
        chk("reset_rd_sop", int'(rd_sop), 0);
        chk("reset_rd_eop", int'(rd_eop), 0);
        chk("reset_rd_vld", int'(rd_vld), 0);
        chk("reset_rd_data", int'(rd_data), 0);
        chk("reset_len_err", int'(len_err), 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_pkt_rdy", int'(pkt_rdy), 1);
        hold_en = 1;

        for (int r = 0; r < 7; r++) begin
            run_pkt(tbl[r].len, tbl[r].mode, done);
            if (tbl[r].len != 0) chk("row_done", done, 1);
            chk("row_beats", n_beat, tbl[r].beats);
            chk("row_reqs", n_req, tbl[r].reqs);
            chk("row_sops", n_sop, tbl[r].sops);
            chk("row_eops", n_eop, tbl[r].eops);
            chk("row_len_err", n_err, tbl[r].errs);
            chk_common("row");
        end

        // Stall: ready low after rd_sop, credit must cap requests at 4.
        clr();
        wait_rdy();
        ready = 1'b0;
        send(6);
        ok = 0;
        for (int i = 0; i < 20 && ok == 0; i++) begin
            @(negedge clk);
            if (n_sop != 0) ok = 1;
        end
        chk("stall_sop", ok, 1);
        repeat (10) @(negedge clk);
        chk("stall_reqs", n_req, 4);
        chk("stall_beats", n_beat, 0);
        ready = 1'b1;
        done = 0;
        for (int i = 0; i < 200 && done == 0; i++) begin
            @(negedge clk);
            if (n_eop != 0) done = 1;
        end
        repeat (3) @(negedge clk);
        chk("stall_done", done, 1);
        chk("stall_beats_end", n_beat, 6);
        chk("stall_reqs_end", n_req, 6);
        chk_common("stall");

        // Reset during the third beat of a 10-word packet.
        clr();
        wait_rdy();
        ready = 1'b1;
        send(10);
        b = 0;
        for (int i = 0; i < 100 && b < 3; i++) begin
            @(negedge clk);
            if (rd_vld) b = b + 1;
        end
        chk("rst_beat3", b, 3);
        hold_en = 0;
        rst_n = 1'b0;
        @(negedge clk);
        chk("rst_pkt_rdy", int'(pkt_rdy), 0);
        chk("rst_xfer_req", int'(xfer_req), 0);
        chk("rst_rd_sop", int'(rd_sop), 0);
        chk("rst_rd_eop", int'(rd_eop), 0);
        chk("rst_rd_vld", int'(rd_vld), 0);
        chk("rst_rd_data", int'(rd_data), 0);
        chk("rst_len_err", int'(len_err), 0);
        rst_n = 1'b1;
        sb.delete();
        clr();
        repeat (6) @(negedge clk);
        chk("rst_no_eop", n_eop, 0);
        chk("rst_no_beat", n_beat, 0);
        chk("rst_no_req", n_req, 0);
        chk("rst_idle_rdy", int'(pkt_rdy), 1);
        hold_en = 1;
        run_pkt(2, 0, done);
        chk("post_rst_done", done, 1);
        chk("post_rst_beats", n_beat, 2);
        chk("post_rst_reqs", n_req, 2);
        chk("post_rst_eops", n_eop, 1);
        chk_common("post_rst");

        // Back-to-back: 511 words then a single-word packet.
        clr();
        wait_rdy();
        ready = 1'b1;
        pkt_length = 9'd511;
        pkt_vld = 1'b1;
        @(negedge clk);
        pkt_length = 9'd1;
        drop = 0;
        done = 0;
        for (int i = 0; i < 3000 && done == 0; i++) begin
            @(negedge clk);
            if (drop != 0) pkt_vld = 1'b0;
            if (pkt_vld && pkt_rdy) drop = 1;
            if (n_eop >= 2) done = 1;
        end
        pkt_vld = 1'b0;
        repeat (3) @(negedge clk);
        chk("b2b_done", done, 1);
        chk("b2b_beats", n_beat, 512);
        chk("b2b_reqs", n_req, 512);
        chk("b2b_sops", n_sop, 2);
        chk("b2b_eops", n_eop, 2);
        chk("b2b_len_err", n_err, 0);
        chk_ge("b2b_gap", min_gap, 2);
        chk_common("b2b");

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
